knn_sorted_list: RTL and testbench
==================================

Name: knn_sorted_list

Overview:
- Parametrised K-deep nearest-neighbour store for the KNN accelerator; generalises the single-neighbour register to K entries kept sorted by ascending distance.
- Candidates (distance, label) stream in through a valid/ready handshake and are insertion-sorted in one cycle.
- An on-demand K-cycle majority-vote FSM produces the classified label.
- Sits between the distance-computation datapath and the KNN software-visible register bank.

Parameters:
DATA_W, 32, distance width (unsigned)
LABEL_W, 8, class label width
K, 4, number of neighbours kept (2..16)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous flush of list and vote result
knn_enable  in  1  global enable; when 0 no insertion or vote start
cand_valid  in  1  candidate present
cand_ready  out  1  block can accept candidate
cand_dist  in  DATA_W  candidate distance
cand_label  in  LABEL_W  candidate label
vote_start  in  1  request majority vote (pulse)
vote_busy  out  1  vote in progress
vote_done  out  1  one-cycle pulse, result valid
vote_label  out  LABEL_W  winning label
vote_count  out  $clog2(K+1)  occurrences of winning label
fill  out  $clog2(K+1)  number of valid entries
nn_dist  out  K*DATA_W  entry i at bits [i*DATA_W +: DATA_W], entry 0 nearest
nn_label  out  K*LABEL_W  entry labels, same packing

Behaviour:
- Reset (rst_n=0, async) and clear (sync): all entry dists = all-ones, labels = 0, entry valid bits = 0, fill=0, FSM=IDLE, vote_label=0, vote_count=0, vote_done=0.
- Handshake: accept when cand_valid & cand_ready & knn_enable. cand_ready=1 only in IDLE and not in clear.
- Insertion, result visible on the cycle after acceptance:
  - position p = number of valid entries with dist <= cand_dist; equal distances go after existing entries (stable).
  - If p==K, candidate is discarded; list is unchanged and fill stays K.
  - Otherwise entries p..K-2 shift to p+1..K-1, the old entry K-1 drops, the candidate is written at p, and fill increments saturating at K.
- Comparison is unsigned over the full DATA_W. A candidate of all-ones is still inserted if a slot is invalid, because the valid bit, not the dist value, marks empty.
- FSM states:
  - IDLE: vote_start & knn_enable moves to VOTE, index i=0, best_count=0, best_label=0.
  - VOTE: one entry per cycle. If entry i is valid, count = number of valid entries whose label equals label[i] (K parallel comparators). Replace best only if count > best_count (strict), so ties resolve to the label of the nearer entry. After i=K-1, go to IDLE, register vote_label/vote_count, and pulse vote_done in the same cycle.
  - Latency from vote_start to vote_done is K+1 cycles. vote_busy=1 while in VOTE.
- Simultaneous events:
  - cand accept and vote_start in the same cycle: the insertion is applied and the vote runs on the updated list.
  - vote_start while busy: ignored.
  - clear during VOTE: abort to IDLE with no vote_done; result registers are zeroed.
  - clear has priority over acceptance.
- Empty list vote: completes in K+1 cycles with vote_label=0, vote_count=0.
- vote_label/vote_count hold until the next completed vote, clear or reset.
- Async reset mid-vote returns to the reset state immediately.

Optional Feature:
- Macro KNN_VOTE_EN.
- Defined: vote FSM as above.
- Undefined: vote logic not built.
  - vote_busy=0, vote_done=0, vote_label=0, vote_count=0; vote_start ignored.
  - cand_ready = ~clear.
  - Sorting behaviour is unchanged.

Test Plan:
- Reset, then K=4, insert dists 50,10,30,20 with labels 1,2,3,4 -> nn_dist = {10,20,30,50}, nn_label = {2,4,3,1}, fill=4.
- Full list {10,20,30,50}, insert dist 60 -> discarded, list unchanged; insert dist 5 label 7 -> list {5,10,20,30}, label 1 dropped.
- Stability: insert (20,label 1), then (20,label 2) -> entry0 label 1, entry1 label 2.
- Vote on labels {2,4,2,4} (dists ascending) -> after 5 cycles vote_done pulses, vote_label=2 (tie, nearer wins), vote_count=2; labels {3,5,5,1} -> label 5, count 2.
- vote_start with fill=0 -> vote_done after 5 cycles, label 0, count 0; cand_ready=0 throughout VOTE; vote_start repeated while busy -> exactly one vote_done.
- clear asserted at VOTE cycle 2 -> no vote_done, fill=0, vote_count=0. rst_n pulsed low mid-insertion without a clock edge -> outputs reset immediately.

Source files
------------

// File: rtl/knn_sorted_list.sv
// K-deep nearest-neighbour list, insertion-sorted by ascending distance; optional majority vote (KNN_VOTE_EN).
// Latency: insertion visible 1 cycle after accept; vote_done K+1 cycles after vote_start.
// Backpressure: cand_ready drops while a vote runs or clear is asserted.
module knn_sorted_list #(
  parameter int DATA_W  = 32,
  parameter int LABEL_W = 8,
  parameter int K       = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     knn_enable,
  input  logic                     cand_valid,
  output logic                     cand_ready,
  input  logic [DATA_W-1:0]        cand_dist,
  input  logic [LABEL_W-1:0]       cand_label,
  input  logic                     vote_start,
  output logic                     vote_busy,
  output logic                     vote_done,
  output logic [LABEL_W-1:0]       vote_label,
  output logic [$clog2(K+1)-1:0]   vote_count,
  output logic [$clog2(K+1)-1:0]   fill,
  output logic [K*DATA_W-1:0]      nn_dist,
  output logic [K*LABEL_W-1:0]     nn_label
);

  localparam int CW = $clog2(K+1);
  localparam int IW = $clog2(K);

  logic [DATA_W-1:0]  dist_q  [K];
  logic [LABEL_W-1:0] label_q [K];
  logic [DATA_W-1:0]  dist_d  [K];
  logic [LABEL_W-1:0] label_d [K];
  logic [K-1:0]       vld_q, vld_d;
  logic [CW-1:0]      fill_q;
  logic [CW-1:0]      pos;
  logic               accept;

  assign accept = cand_valid & cand_ready & knn_enable;

  // Valid entries form a prefix, so counting <= gives a stable insert position.
  always_comb begin
    pos = '0;
    for (int j = 0; j < K; j++)
      if (vld_q[j] && (dist_q[j] <= cand_dist)) pos = pos + CW'(1);
  end

  always_comb begin
    dist_d  = dist_q;
    label_d = label_q;
    vld_d   = vld_q;
    if (pos != CW'(K)) begin
      for (int j = K-1; j >= 1; j--) begin
        if (CW'(j) > pos) begin
          dist_d[j]  = dist_q[j-1];
          label_d[j] = label_q[j-1];
          vld_d[j]   = vld_q[j-1];
        end
      end
      for (int j = 0; j < K; j++) begin
        if (CW'(j) == pos) begin
          dist_d[j]  = cand_dist;
          label_d[j] = cand_label;
          vld_d[j]   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < K; j++) begin
        dist_q[j]  <= '1;
        label_q[j] <= '0;
      end
      vld_q  <= '0;
      fill_q <= '0;
    end else if (clear) begin
      for (int j = 0; j < K; j++) begin
        dist_q[j]  <= '1;
        label_q[j] <= '0;
      end
      vld_q  <= '0;
      fill_q <= '0;
    end else if (accept) begin
      dist_q  <= dist_d;
      label_q <= label_d;
      vld_q   <= vld_d;
      fill_q  <= (fill_q == CW'(K)) ? fill_q : fill_q + CW'(1);
    end
  end

  assign fill = fill_q;

  for (genvar g = 0; g < K; g++) begin : g_pack
    assign nn_dist[g*DATA_W +: DATA_W]    = dist_q[g];
    assign nn_label[g*LABEL_W +: LABEL_W] = label_q[g];
  end

`ifdef KNN_VOTE_EN
  localparam logic S_IDLE = 1'b0;
  localparam logic S_VOTE = 1'b1;

  logic               state_q;
  logic [IW-1:0]      idx_q;
  logic [CW-1:0]      best_cnt_q, cur_cnt, res_cnt_q;
  logic [LABEL_W-1:0] best_lbl_q, res_lbl_q;
  logic               done_q;
  logic               take;

  always_comb begin
    cur_cnt = '0;
    if (vld_q[idx_q])
      for (int j = 0; j < K; j++)
        if (vld_q[j] && (label_q[j] == label_q[idx_q])) cur_cnt = cur_cnt + CW'(1);
  end

  // Strict compare keeps the earlier (nearer) label on ties.
  assign take = cur_cnt > best_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      best_cnt_q <= '0;
      best_lbl_q <= '0;
      res_cnt_q  <= '0;
      res_lbl_q  <= '0;
      done_q     <= 1'b0;
    end else if (clear) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      best_cnt_q <= '0;
      best_lbl_q <= '0;
      res_cnt_q  <= '0;
      res_lbl_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (vote_start && knn_enable) begin
            state_q    <= S_VOTE;
            idx_q      <= '0;
            best_cnt_q <= '0;
            best_lbl_q <= '0;
          end
        end
        default: begin
          if (take) begin
            best_cnt_q <= cur_cnt;
            best_lbl_q <= label_q[idx_q];
          end
          if (idx_q == IW'(K-1)) begin
            state_q   <= S_IDLE;
            done_q    <= 1'b1;
            res_cnt_q <= take ? cur_cnt : best_cnt_q;
            res_lbl_q <= take ? label_q[idx_q] : best_lbl_q;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
      endcase
    end
  end

  assign cand_ready = (state_q == S_IDLE) & ~clear;
  assign vote_busy  = (state_q == S_VOTE);
  assign vote_done  = done_q;
  assign vote_label = res_lbl_q;
  assign vote_count = res_cnt_q;
`else
  logic unused_vote;
  assign unused_vote = vote_start;
  assign cand_ready  = ~clear;
  assign vote_busy   = 1'b0;
  assign vote_done   = 1'b0;
  assign vote_label  = '0;
  assign vote_count  = '0;
`endif

endmodule

// File: tb/tb_knn_sorted_list.sv
// Directed bench for knn_sorted_list at K=4; vote checks only when KNN_VOTE_EN is defined.
module tb_knn_sorted_list;
  localparam int DATA_W  = 32;
  localparam int LABEL_W = 8;
  localparam int K       = 4;
  localparam int CW      = $clog2(K+1);
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  logic                 clk = 1'b0;
  logic                 rst_n, clear, knn_enable, cand_valid, vote_start;
  logic                 cand_ready, vote_busy, vote_done;
  logic [DATA_W-1:0]    cand_dist;
  logic [LABEL_W-1:0]   cand_label, vote_label;
  logic [CW-1:0]        vote_count, fill;
  logic [K*DATA_W-1:0]  nn_dist;
  logic [K*LABEL_W-1:0] nn_label;

  int total = 0;
  int bad   = 0;

  knn_sorted_list #(.DATA_W(DATA_W), .LABEL_W(LABEL_W), .K(K)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .knn_enable(knn_enable),
    .cand_valid(cand_valid), .cand_ready(cand_ready),
    .cand_dist(cand_dist), .cand_label(cand_label),
    .vote_start(vote_start), .vote_busy(vote_busy), .vote_done(vote_done),
    .vote_label(vote_label), .vote_count(vote_count), .fill(fill),
    .nn_dist(nn_dist), .nn_label(nn_label)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pd(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [31:0] pl(input logic [7:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic insert(input logic [31:0] d, input logic [7:0] l);
    @(negedge clk);
    cand_valid = 1'b1;
    cand_dist  = d;
    cand_label = l;
    @(negedge clk);
    cand_valid = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    #1 chk("ready_in_clear", cand_ready, 0);
    @(negedge clk);
    clear = 1'b0;
  endtask

  // Pulses vote_start (held hold_extra more cycles), optionally clears at cycle clear_at,
  // and reports the cycle of the first vote_done and the number of done pulses.
  task automatic run_vote(input int hold_extra, input int clear_at,
                          output int lat, output int ndone, output logic busy1, output logic rdy1);
    lat = 0;
    ndone = 0;
    busy1 = 1'b0;
    rdy1 = 1'b1;
    @(negedge clk);
    vote_start = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 1) begin
        busy1 = vote_busy;
        rdy1  = cand_ready;
      end
      if (vote_done) begin
        ndone++;
        if (lat == 0) lat = n;
      end
      if (n > hold_extra) vote_start = 1'b0;
      clear = (n == clear_at);
    end
    clear = 1'b0;
  endtask

  int   lat, ndone;
  logic busy1, rdy1;

  initial begin
    rst_n = 1'b0; clear = 1'b0; knn_enable = 1'b1; cand_valid = 1'b0;
    cand_dist = '0; cand_label = '0; vote_start = 1'b0;
    #12;
    chk("rst_fill", fill, 0);
    chk("rst_dist", nn_dist, pd(ONES, ONES, ONES, ONES));
    chk("rst_label", nn_label, 0);
    chk("rst_vote", {vote_busy, vote_done, vote_label, vote_count}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    insert(50, 1); insert(10, 2); insert(30, 3); insert(20, 4);
    chk("sort_dist", nn_dist, pd(10, 20, 30, 50));
    chk("sort_label", nn_label, pl(2, 4, 3, 1));
    chk("sort_fill", fill, 4);

    insert(60, 9);
    chk("discard_dist", nn_dist, pd(10, 20, 30, 50));
    chk("discard_label", nn_label, pl(2, 4, 3, 1));
    chk("discard_fill", fill, 4);

    insert(5, 7);
    chk("front_dist", nn_dist, pd(5, 10, 20, 30));
    chk("front_label", nn_label, pl(7, 2, 4, 3));

    do_clear();
    chk("clr_fill", fill, 0);
    chk("clr_dist", nn_dist, pd(ONES, ONES, ONES, ONES));

    insert(20, 1); insert(20, 2);
    chk("stable_label", nn_label, pl(1, 2, 0, 0));
    chk("stable_dist", nn_dist, pd(20, 20, ONES, ONES));
    insert(ONES, 5);
    chk("ones_fill", fill, 3);
    chk("ones_label", nn_label, pl(1, 2, 5, 0));

    knn_enable = 1'b0;
    insert(3, 6);
    chk("disabled_fill", fill, 3);
    knn_enable = 1'b1;

`ifdef KNN_VOTE_EN
    do_clear();
    run_vote(0, 0, lat, ndone, busy1, rdy1);
    chk("empty_lat", lat, K + 1);
    chk("empty_res", {vote_label, vote_count}, 0);
    chk("busy_in_vote", busy1, 1);
    chk("ready_in_vote", rdy1, 0);

    insert(10, 2); insert(20, 4); insert(30, 2); insert(40, 4);
    run_vote(2, 0, lat, ndone, busy1, rdy1);
    chk("tie_lat", lat, K + 1);
    chk("tie_ndone", ndone, 1);
    chk("tie_label", vote_label, 2);
    chk("tie_count", vote_count, 2);

    do_clear();
    insert(10, 3); insert(20, 5); insert(30, 5); insert(40, 1);
    run_vote(0, 0, lat, ndone, busy1, rdy1);
    chk("maj_label", vote_label, 5);
    chk("maj_count", vote_count, 2);

    run_vote(0, 2, lat, ndone, busy1, rdy1);
    chk("abort_ndone", ndone, 0);
    chk("abort_fill", fill, 0);
    chk("abort_res", {vote_label, vote_count}, 0);
    chk("abort_busy", vote_busy, 0);
`else
    @(negedge clk);
    vote_start = 1'b1;
    @(negedge clk);
    vote_start = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (vote_busy || vote_done) chk("novote_idle", {vote_busy, vote_done}, 0);
    end
    chk("novote_res", {vote_label, vote_count}, 0);
    chk("novote_ready", cand_ready, 1);
`endif

    insert(10, 2);
    @(negedge clk);
    cand_valid = 1'b1;
    cand_dist  = 7;
    cand_label = 3;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_fill", fill, 0);
    chk("arst_dist", nn_dist, pd(ONES, ONES, ONES, ONES));
    chk("arst_label", nn_label, 0);
    chk("arst_vote", {vote_busy, vote_done, vote_label, vote_count}, 0);
    cand_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
